tick_ctrl: RTL and testbench

Run-control and rate generator feeding the 0–24 step counter's `enable` input. It turns two push-buttons (start, stop) into a run/pause/idle state machine. While running, it emits a one-cycle enable pulse every `DIV` clocks, so the counter advances at a fixed human-visible rate. Button inputs are synchronised and, optionally, debounced.

---
 rtl/tick_ctrl.sv | 143 ++++++++++++++
 tb/tb_tick_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_ctrl.sv
// Run/pause/idle control from start/stop buttons plus a DIV-clock enable pulse generator; TICK_CTRL_DEBOUNCE_EN adds per-button debounce.
// Latency: press to state change is 3 edges, or 3+DEBOUNCE_CYCLES with debounce; o_enable and o_running are registered.
// Backpressure: none; o_enable is a free-running one-cycle pulse while in RUN.
module tick_ctrl #(
    parameter int DIV             = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_start,
    input  logic i_btn_stop,
    output logic o_enable,
    output logic o_running
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] prescaler, prescaler_nxt;
    logic          enable_nxt;

    // Bit 0 carries start, bit 1 carries stop through the whole input path.
    logic [1:0] btn_raw;
    logic [1:0] sync1, sync2;
    logic [1:0] btn_filt;
    logic [1:0] btn_dly;
    logic [1:0] press;
    logic       start_ev, stop_ev;

    assign btn_raw = {i_btn_stop, i_btn_start};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef TICK_CTRL_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [DBW-1:0] db_cnt [2];
    logic [1:0]     db_stable;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            db_stable <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_stable[i] <= sync2[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign btn_filt = db_stable;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign btn_filt = sync2;
`endif

    // Registered press pulse: one cycle per rising filtered level.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            btn_dly <= '0;
            press   <= '0;
        end else begin
            btn_dly <= btn_filt;
            press   <= btn_filt & ~btn_dly;
        end
    end

    assign start_ev = press[0];
    assign stop_ev  = press[1];

    always_comb begin
        state_nxt     = state;
        prescaler_nxt = prescaler;
        enable_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (start_ev && !stop_ev) state_nxt = RUN;
            end
            RUN: begin
                if (stop_ev) state_nxt = PAUSE;
            end
            PAUSE: begin
                if (stop_ev)       state_nxt = IDLE;
                else if (start_ev) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase

        // Only a full cycle spent in RUN advances the rate divider.
        if (state == RUN && state_nxt == RUN) begin
            if (prescaler == PS_LAST) begin
                prescaler_nxt = '0;
                enable_nxt    = 1'b1;
            end else begin
                prescaler_nxt = prescaler + PW'(1);
            end
        end

        if (state_nxt == IDLE) prescaler_nxt = '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            prescaler <= '0;
            o_enable  <= 1'b0;
            o_running <= 1'b0;
        end else begin
            state     <= state_nxt;
            prescaler <= prescaler_nxt;
            o_enable  <= enable_nxt;
            o_running <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_tick_ctrl.sv
// Bench for tick_ctrl: directed scenarios then random button traffic, checked against a cycle-level behavioural model.
module tb_tick_ctrl;

    localparam int DIV = 4;
    localparam int DEB = 3;
`ifdef TICK_CTRL_DEBOUNCE_EN
    localparam int LAT        = 3 + DEB;
    localparam int BOUNCE_RUN = 0;
`else
    localparam int LAT        = 3;
    localparam int BOUNCE_RUN = 1;
`endif

    logic i_clk     = 1'b0;
    logic i_rst_n   = 1'b0;
    logic btn_start = 1'b0;
    logic btn_stop  = 1'b0;
    logic o_enable;
    logic o_running;

    always #5 i_clk = ~i_clk;

    tick_ctrl #(
        .DIV             (DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_btn_start (btn_start),
        .i_btn_stop  (btn_stop),
        .o_enable    (o_enable),
        .o_running   (o_running)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_runs  = 0;     // RUN cycles accumulated since last IDLE
    logic    m_en    = 1'b0;
    logic    m_run   = 1'b0;
    logic    hist [2][8];     // raw samples, index k = k edges ago
    logic    stab [2];
    logic    f1 [2];
    logic    f2 [2];
    logic    prs [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model of one rising edge given the inputs sampled there.
    task automatic model_edge(input logic rst_n, input logic [1:0] raw);
        mstate_t nxt;
        logic    f;
        logic    flip;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_runs  = 0;
            m_en    = 1'b0;
            m_run   = 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) hist[b][k] = 1'b0;
                stab[b] = 1'b0;
                f1[b]   = 1'b0;
                f2[b]   = 1'b0;
                prs[b]  = 1'b0;
            end
        end else begin
            nxt = m_state;
            if (prs[1])      nxt = (m_state == M_RUN) ? M_PAUSE : M_IDLE;
            else if (prs[0]) nxt = M_RUN;
            m_en = 1'b0;
            if (m_state == M_RUN && nxt == M_RUN) begin
                m_runs++;
                m_en = ((m_runs % DIV) == 0);
            end
            if (nxt == M_IDLE) m_runs = 0;
            m_state = nxt;
            m_run   = (nxt == M_RUN);
            for (int b = 0; b < 2; b++) begin
                for (int k = 7; k > 0; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = raw[b];
`ifdef TICK_CTRL_DEBOUNCE_EN
                flip = 1'b1;
                for (int k = 2; k <= DEB + 1; k++) begin
                    if (hist[b][k] == stab[b]) flip = 1'b0;
                end
                if (flip) stab[b] = ~stab[b];
                f = stab[b];
`else
                flip = 1'b0;
                f    = hist[b][1] | flip;
`endif
                prs[b] = f1[b] & ~f2[b];
                f2[b]  = f1[b];
                f1[b]  = f;
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic st, input logic sp);
        i_rst_n   = rst_n;
        btn_start = st;
        btn_stop  = sp;
        model_edge(rst_n, {sp, st});
        @(posedge i_clk);
        #1;
        chk("enable", o_enable, m_en);
        chk("running", o_running, m_run);
    endtask

    initial begin
        logic [4:0] pat;
        int         npulse;
        int         p_hold;
        logic       found;
        logic       rs, rp;

        // Reset held while buttons toggle
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i[0], ~i[0]);
            chk("rst_enable", o_enable, 0);
            chk("rst_running", o_running, 0);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("idle_running", o_running, 0);
        end

        // Bounce: high 2, low 1, high 2, then low
        pat = 5'b11011;
        for (int i = 0; i < 5; i++) step(1'b1, pat[i], 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        chk("bounce_running", o_running, BOUNCE_RUN);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Start from IDLE, button held 10 cycles; step k lands on edge k
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, k < 10, 1'b0);
            if (k == LAT - 1)       chk("start_not_yet", o_running, 0);
            if (k == LAT)           chk("start_running", o_running, 1);
            if (k == LAT + DIV - 1) chk("pre_pulse", o_enable, 0);
            if (k == LAT + DIV)     chk("first_pulse", o_enable, 1);
            if (k == LAT + DIV + 1) chk("pulse_width", o_enable, 0);
            npulse += int'(o_enable);
        end
        chk("pulse_count", npulse, (19 - LAT) / DIV);

        // Pause, then resume from the held prescaler value
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++) step(1'b1, 1'b0, k < 6);
        chk("paused_running", o_running, 0);
        chk("pause_hold", m_runs % DIV, 2);
        p_hold = m_runs % DIV;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k < 6, 1'b0);
            if (k == LAT)                chk("resume_running", o_running, 1);
            if (k == LAT + DIV - p_hold) chk("resume_pulse", o_enable, 1);
        end

        // Simultaneous start+stop in RUN, then stop alone to IDLE
        for (int k = 0; k < 12; k++) step(1'b1, k < 6, k < 6);
        chk("simul_running", o_running, 0);
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, k < 6);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k < 6, 1'b0);
            if (k == LAT + DIV - 1) chk("clear_pre_pulse", o_enable, 0);
            if (k == LAT + DIV)     chk("clear_first_pulse", o_enable, 1);
        end

        // Reset one cycle before a pulse is due
        found = 1'b0;
        for (int i = 0; i < 3 * DIV && !found; i++) begin
            if (m_state == M_RUN && (m_runs % DIV) == DIV - 1) found = 1'b1;
            else step(1'b1, 1'b0, 1'b0);
        end
        chk("midrst_found", found, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("midrst_enable", o_enable, 0);
        chk("midrst_running", o_running, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        chk("midrst_idle", o_running, 0);

        // Random button traffic with rare resets
        rs = 1'b0;
        rp = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0)  rs = ~rs;
            if ($urandom_range(0, 13) == 0) rp = ~rp;
            step($urandom_range(0, 299) != 0, rs, rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
